// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared types and helpers for the ADC scan sequencer
package adc_pkg;

    typedef enum logic [1:0] {IDLE, START, WAIT, OUT} scan_state_t;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scan_timeout_timer.sv
// rtl/scan_timeout_timer.sv - loadable conversion timeout down-counter
module scan_timeout_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);
    // The START cycle is the first of the TIMEOUT cycles, so WAIT counts one fewer.
    localparam logic [W-1:0] LOAD_VAL = W'(TIMEOUT - 1);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = LOAD_VAL;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/adc_scan_sequencer.sv
// rtl/adc_scan_sequencer.sv - per-tick channel scan with converter handshake and result stream
module adc_scan_sequencer
    import adc_pkg::*;
#(
    parameter int NUM_CH  = 5,
    parameter int DATA_W  = 12,
    parameter int TIMEOUT = 64,
    localparam int CH_W   = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              sample_tick,
    output logic              adc_start,
    output logic [CH_W-1:0]   adc_ch,
    input  logic              adc_done,
    input  logic [DATA_W-1:0] adc_data,
    output logic              s_valid,
    input  logic              s_ready,
    output logic [DATA_W-1:0] s_data,
    output logic [CH_W-1:0]   s_ch,
    output logic              s_last,
    output logic              s_err,
    output logic              busy,
    output logic              overrun,
    input  logic              overrun_clr
);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    scan_state_t       state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic              overrun_q, overrun_d;
    logic              tmr_load, tmr_en, tmr_expired;

    scan_timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (reset),
        .load    (tmr_load),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        data_d   = data_q;
        err_d    = err_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sample_tick && enable) begin
                    ch_d    = '0;
                    state_d = START;
                end
            end
            START: begin
                tmr_load = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                tmr_en = 1'b1;
                // A done on the last counted cycle still beats the timeout.
                if (adc_done) begin
                    data_d  = adc_data;
                    err_d   = 1'b0;
                    state_d = OUT;
                end else if (tmr_expired) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (s_ready) begin
                    if (ch_q == LAST_CH) begin
                        state_d = IDLE;
                    end else begin
                        ch_d    = ch_q + 1'b1;
                        state_d = START;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Any tick while a frame is active is dropped; set has priority over clear.
    always_comb begin
        overrun_d = overrun_q;
        if (sample_tick && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            data_q    <= data_d;
            err_q     <= err_d;
            overrun_q <= overrun_d;
        end
    end

    assign adc_start = (state_q == START);
    assign adc_ch    = ch_q;
    assign s_valid   = (state_q == OUT);
    assign s_data    = data_q;
    assign s_ch      = ch_q;
    assign s_err     = err_q;
    assign s_last    = (state_q == OUT) && (ch_q == LAST_CH);
    assign busy      = (state_q != IDLE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb/tb_adc_scan_sequencer.sv - self-checking bench for adc_scan_sequencer
module tb_adc_scan_sequencer;
    localparam int NUM_CH  = 5;
    localparam int DATA_W  = 12;
    localparam int TIMEOUT = 64;
    localparam int CH_W    = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic              sample_tick = 1'b0;
    logic              adc_start;
    logic [CH_W-1:0]   adc_ch;
    logic              adc_done = 1'b0;
    logic [DATA_W-1:0] adc_data = '0;
    logic              s_valid;
    logic              s_ready = 1'b0;
    logic [DATA_W-1:0] s_data;
    logic [CH_W-1:0]   s_ch;
    logic              s_last;
    logic              s_err;
    logic              busy;
    logic              overrun;
    logic              overrun_clr = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;
    int lat_cfg   [NUM_CH];
    int stall_cfg [NUM_CH];

    always #5 clk = ~clk;

    adc_scan_sequencer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .enable(enable), .sample_tick(sample_tick),
        .adc_start(adc_start), .adc_ch(adc_ch), .adc_done(adc_done), .adc_data(adc_data),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_ch(s_ch),
        .s_last(s_last), .s_err(s_err), .busy(busy), .overrun(overrun),
        .overrun_clr(overrun_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_cfg(input int max_lat, input int max_stall);
        for (int c = 0; c < NUM_CH; c++) begin
            lat_cfg[c]   = $urandom_range(max_lat, 1);
            stall_cfg[c] = $urandom_range(max_stall, 0);
        end
    endtask

    // lat_cfg[c]==0 means the converter never answers on that channel.
    task automatic run_frame(input int inj_ch, input bit inj_clr, input int en_off_ch,
                             input bit tick_at_end, input int abort_ch);
        int                k;
        bit                bad;
        int                exp_k;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] exp_d;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            check($sformatf("start ch%0d", c), adc_start, 1);
            check($sformatf("start_ch ch%0d", c), adc_ch, c);
            check($sformatf("busy ch%0d", c), busy, 1);
            if (en_off_ch == c) enable = 1'b0;
            d     = DATA_W'($urandom);
            exp_k = (lat_cfg[c] == 0) ? TIMEOUT + 1 : lat_cfg[c] + 1;
            exp_d = (lat_cfg[c] == 0) ? '0 : d;
            if (inj_ch == c) begin
                sample_tick = 1'b1;
                overrun_clr = inj_clr;
            end
            bad = 1'b0;
            for (k = 1; k <= TIMEOUT + 4; k++) begin
                step();
                sample_tick = 1'b0;
                overrun_clr = 1'b0;
                if (k == 1 && inj_ch == c) check("overrun_set", overrun, 1);
                if (abort_ch == c && k == 3) begin
                    reset = 1'b1;
                    #1;
                    check("rst_adc_start", adc_start, 0);
                    check("rst_s_valid", s_valid, 0);
                    check("rst_busy", busy, 0);
                    check("rst_adc_ch", adc_ch, 0);
                    step();
                    reset    = 1'b0;
                    adc_done = 1'b1;
                    adc_data = d;
                    step();
                    adc_done = 1'b0;
                    step();
                    check("late_done_valid", s_valid, 0);
                    check("late_done_busy", busy, 0);
                    return;
                end
                if (s_valid) break;
                if (adc_start || adc_ch != CH_W'(c)) bad = 1'b1;
                adc_done = (k == lat_cfg[c]);
                adc_data = adc_done ? d : DATA_W'($urandom);
            end
            adc_done = 1'b0;
            check($sformatf("valid_latency ch%0d", c), k, exp_k);
            check($sformatf("wait_stable ch%0d", c), bad, 0);
            check($sformatf("s_data ch%0d", c), s_data, exp_d);
            check($sformatf("s_ch ch%0d", c), s_ch, c);
            check($sformatf("s_err ch%0d", c), s_err, lat_cfg[c] == 0);
            check($sformatf("s_last ch%0d", c), s_last, c == NUM_CH - 1);
            if (stall_cfg[c] > 0) begin
                bad = 1'b0;
                for (int j = 0; j < stall_cfg[c]; j++) begin
                    s_ready = 1'b0;
                    step();
                    if (!s_valid || s_data !== exp_d || s_ch !== CH_W'(c) || adc_start) bad = 1'b1;
                end
                check($sformatf("hold ch%0d", c), bad, 0);
            end
            s_ready = 1'b1;
            if (tick_at_end && c == NUM_CH - 1) sample_tick = 1'b1;
            step();
            s_ready     = 1'b0;
            sample_tick = 1'b0;
        end
        check("busy_end", busy, 0);
        check("no_restart", adc_start, 0);
        if (tick_at_end) check("overrun_end", overrun, 1);
    endtask

    task automatic clear_overrun();
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        check("overrun_clr", overrun, 0);
    endtask

    task automatic idle_tick_ignored(input string tag);
        bit bad;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (adc_start || busy) bad = 1'b1;
            step();
        end
        check({tag, "_no_start"}, bad, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        #2;
        check("reset_adc_start", adc_start, 0);
        check("reset_adc_ch", adc_ch, 0);
        check("reset_s_valid", s_valid, 0);
        check("reset_s_data", s_data, 0);
        check("reset_s_ch", s_ch, 0);
        check("reset_s_last", s_last, 0);
        check("reset_s_err", s_err, 0);
        check("reset_busy", busy, 0);
        check("reset_overrun", overrun, 0);
        step();
        reset = 1'b0;
        step();

        idle_tick_ignored("disabled");
        enable = 1'b1;
        step();

        for (int c = 0; c < NUM_CH; c++) begin
            lat_cfg[c]   = 3;
            stall_cfg[c] = 0;
        end
        run_frame(-1, 0, -1, 0, -1);

        randomize_cfg(6, 2);
        stall_cfg[2] = 10;
        run_frame(-1, 0, -1, 0, -1);

        randomize_cfg(8, 3);
        lat_cfg[1] = 0;
        run_frame(-1, 0, -1, 0, -1);

        randomize_cfg(5, 1);
        lat_cfg[0] = TIMEOUT;
        lat_cfg[4] = 1;
        run_frame(2, 0, -1, 0, -1);
        step();
        check("overrun_sticky", overrun, 1);
        clear_overrun();

        randomize_cfg(5, 2);
        run_frame(1, 1, -1, 0, -1);
        clear_overrun();

        randomize_cfg(4, 1);
        run_frame(-1, 0, -1, 1, -1);
        clear_overrun();

        randomize_cfg(4, 0);
        lat_cfg[3] = 0;
        run_frame(-1, 0, -1, 0, 3);
        check("post_reset_overrun", overrun, 0);

        randomize_cfg(6, 2);
        run_frame(-1, 0, -1, 0, -1);

        randomize_cfg(6, 1);
        run_frame(-1, 0, 2, 0, -1);
        idle_tick_ignored("enable_off");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
